perceptron_infer_engine: RTL and testbench

Fixed-point perceptron inference engine. It is the consumer of the weights and bias a perceptron trainer produces: weights are written in over a load port, then input vectors stream in and predictions stream out. It sits downstream of the training block. It computes one multiply-accumulate per clock, so it is synthesizable, unlike the real-valued training model.

---
 rtl/perceptron_infer_engine_if.sv | 42 ++++
 rtl/perceptron_infer_engine.sv | 151 +++++++++++++++
 tb/tb_perceptron_infer_engine.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perceptron_infer_engine_if.sv
// Load, sample and result channels of the perceptron inference engine.
// master = producer side (trainer / sample source / result sink), slave = engine.
interface perceptron_infer_engine_if #(
    parameter int unsigned SIZE = 2,
    parameter int unsigned DW   = 16
);
    localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic                 wt_valid;
    logic                 wt_ready;
    logic                 wt_is_bias;
    logic [IW-1:0]        wt_idx;
    logic [DW-1:0]        wt_data;

    logic                 in_valid;
    logic                 in_ready;
    logic [SIZE*DW-1:0]   in_data;
    logic [1:0]           activation;

    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_pred;
    logic [DW-1:0]        out_sum;

    modport master (
        output wt_valid, wt_is_bias, wt_idx, wt_data,
        input  wt_ready,
        output in_valid, in_data, activation,
        input  in_ready,
        input  out_valid, out_pred, out_sum,
        output out_ready
    );

    modport slave (
        input  wt_valid, wt_is_bias, wt_idx, wt_data,
        output wt_ready,
        input  in_valid, in_data, activation,
        output in_ready,
        output out_valid, out_pred, out_sum,
        input  out_ready
    );
endinterface

// File: rtl/perceptron_infer_engine.sv
// Fixed-point perceptron inference: one MAC per clock, saturated sum, selectable activation.
// Optional hard-sigmoid activation (code 3) is enabled by defining PERCEPTRON_HARDSIG_EN.
module perceptron_infer_engine #(
    parameter int unsigned SIZE  = 2,
    parameter int unsigned DW    = 16,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACC_W = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    perceptron_infer_engine_if.slave bus
);
    localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned PW = 2 * DW;

    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] ONE   = DW'(1 << FRAC);
`ifdef PERCEPTRON_HARDSIG_EN
    localparam logic signed [DW-1:0] HALF  = DW'(1 << (FRAC - 1));
`endif

    typedef enum logic [1:0] {IDLE, MAC, ACT, OUT} state_t;

    state_t                   state;
    logic signed [DW-1:0]     weights [SIZE];
    logic signed [DW-1:0]     bias;
    logic [SIZE*DW-1:0]       x_q;
    logic [1:0]               act_q;
    logic signed [ACC_W-1:0]  acc;
    logic [IW-1:0]            k;
    logic                     out_valid_q;
    logic signed [DW-1:0]     pred_q;
    logic signed [DW-1:0]     sum_q;

    logic                     idx_ok_c;
    logic signed [DW-1:0]     x_elem_c;
    logic signed [PW-1:0]     prod_c;
    logic signed [ACC_W-1:0]  acc_next_c;
    logic signed [ACC_W-1:0]  bias_ext_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic [ACC_W-DW:0]        hi_c;
    logic                     ovf_c;
    logic signed [DW-1:0]     sum_c;
    logic signed [DW-1:0]     pred_c;
`ifdef PERCEPTRON_HARDSIG_EN
    logic signed [DW-1:0]     hs_c;
`endif

    // Datapath: MAC step, bias preload, rescale with saturation, activation
    always_comb begin
        idx_ok_c   = ({1'b0, bus.wt_idx} < (IW+1)'(SIZE));
        x_elem_c   = x_q[k*DW +: DW];
        prod_c     = PW'(weights[k]) * PW'(x_elem_c);
        acc_next_c = acc + ACC_W'(prod_c);
        bias_ext_c = ACC_W'(bias) <<< FRAC;
        shifted_c  = acc >>> FRAC;
        // In range only when every bit above the DW-1 sign bit matches it
        hi_c       = shifted_c[ACC_W-1:DW-1];
        ovf_c      = !((&hi_c) || !(|hi_c));
        sum_c      = shifted_c[DW-1:0];
        if (ovf_c) begin
            sum_c = shifted_c[ACC_W-1] ? S_MIN : S_MAX;
        end
`ifdef PERCEPTRON_HARDSIG_EN
        hs_c = (sum_c >>> 2) + HALF;
`endif
        pred_c = sum_c;
        case (act_q)
            2'd0:    pred_c = sum_c[DW-1] ? '0 : ONE;
            2'd1:    pred_c = sum_c[DW-1] ? '0 : sum_c;
            2'd2:    pred_c = sum_c;
            default: begin
`ifdef PERCEPTRON_HARDSIG_EN
                if (hs_c[DW-1]) begin
                    pred_c = '0;
                end else if (hs_c > ONE) begin
                    pred_c = ONE;
                end else begin
                    pred_c = hs_c;
                end
`else
                pred_c = sum_c;
`endif
            end
        endcase
    end

    // Control FSM, weight store and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            for (int unsigned i = 0; i < SIZE; i++) begin
                weights[i] <= '0;
            end
            bias        <= '0;
            x_q         <= '0;
            act_q       <= '0;
            acc         <= '0;
            k           <= '0;
            out_valid_q <= 1'b0;
            pred_q      <= '0;
            sum_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wt_valid) begin
                        if (bus.wt_is_bias) begin
                            bias <= bus.wt_data;
                        end else if (idx_ok_c) begin
                            weights[bus.wt_idx] <= bus.wt_data;
                        end
                    end else if (bus.in_valid) begin
                        x_q   <= bus.in_data;
                        act_q <= bus.activation;
                        acc   <= bias_ext_c;
                        k     <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next_c;
                    k   <= k + 1'b1;
                    if (k == IW'(SIZE - 1)) begin
                        state <= ACT;
                    end
                end
                ACT: begin
                    sum_q       <= sum_c;
                    pred_q      <= pred_c;
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wt_ready  = (state == IDLE);
    assign bus.in_ready  = (state == IDLE) && !bus.wt_valid;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pred  = pred_q;
    assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_perceptron_infer_engine.sv
// Scoreboard bench for perceptron_infer_engine: model results queued at sample accept, compared at result handshake.
module tb_perceptron_infer_engine;
    localparam int unsigned SIZE = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned FRAC = 8;
    localparam int unsigned ACC_W = 40;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    perceptron_infer_engine_if #(.SIZE(SIZE), .DW(DW)) bus ();

    perceptron_infer_engine #(.SIZE(SIZE), .DW(DW), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] w_m [SIZE];
    logic [15:0] b_m;
    logic [31:0] exp_q [$];
    int          acc_q [$];
    bit          prev_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: bias*2^FRAC + sum(w*x), >>> FRAC, saturate, activate
    function automatic logic [31:0] model(input logic [15:0] x0, input logic [15:0] x1, input logic [1:0] act);
        longint a, s, h;
        logic [15:0] sv, pv;
        a = longint'($signed(b_m)) * 256;
        a += longint'($signed(w_m[0])) * longint'($signed(x0));
        a += longint'($signed(w_m[1])) * longint'($signed(x1));
        s = a >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        sv = 16'(s);
        h  = 0;
        case (act)
            2'd0: pv = (s >= 0) ? 16'h0100 : 16'h0000;
            2'd1: pv = (s > 0) ? sv : 16'h0000;
            2'd2: pv = sv;
            default: begin
`ifdef PERCEPTRON_HARDSIG_EN
                h = (s >>> 2) + 128;
                if (h < 0) h = 0;
                if (h > 256) h = 256;
                pv = 16'(h);
`else
                pv = sv;
`endif
            end
        endcase
        return {sv, pv};
    endfunction

    // Result monitor: latency on rising out_valid, values on handshake
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.out_valid && !prev_valid) begin
            if (acc_q.size() == 0) check("lat_unexp", bus.out_valid, 0);
            else check("latency", cyc - acc_q.pop_front(), SIZE + 1);
        end
        prev_valid = bus.out_valid;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexp", bus.out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", bus.out_sum, e[31:16]);
                check("out_pred", bus.out_pred, e[15:0]);
            end
        end
    end

    task automatic wr(input bit isb, input logic [0:0] idx, input logic [15:0] d);
        bit ok = 0;
        bus.wt_valid = 1; bus.wt_is_bias = isb; bus.wt_idx = idx; bus.wt_data = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.wt_ready) begin ok = 1; break; end
        end
        if (!ok) check("wr_timeout", bus.wt_ready, 1);
        @(posedge clk); #1;
        bus.wt_valid = 0;
        if (ok) begin
            if (isb) b_m = d;
            else w_m[idx] = d;
        end
    endtask

    task automatic send(input logic [15:0] x0, input logic [15:0] x1, input logic [1:0] act);
        bit ok = 0;
        bus.in_valid = 1; bus.in_data = {x1, x0}; bus.activation = act;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1; break; end
        end
        if (!ok) check("send_timeout", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 0;
        if (ok) begin
            exp_q.push_back(model(x0, x1, act));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            if (exp_q.size() == 0 && !bus.out_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int n = 0; n < 50; n++) begin
            if (bus.out_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("valid_timeout", bus.out_valid, 1);
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        w_m[0] = '0; w_m[1] = '0; b_m = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sv, pv;
        int last;
        rst_n = 0;
        bus.wt_valid = 0; bus.wt_is_bias = 0; bus.wt_idx = '0; bus.wt_data = '0;
        bus.in_valid = 0; bus.in_data = '0; bus.activation = '0; bus.out_ready = 1;
        clear_model();
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_wt_ready", bus.wt_ready, 1);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_pred", bus.out_pred, 0);
        check("rst_out_sum", bus.out_sum, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Basic step with bias -1.0
        wr(0, 0, 16'h0100); wr(0, 1, 16'h0100); wr(1, 0, 16'hFF00);
        send(16'h0100, 16'h0100, 2'd0); drain();
        check("t1_sum", bus.out_sum, 16'h0100);
        check("t1_pred", bus.out_pred, 16'h0100);

        send(16'h0000, 16'h0000, 2'd0); drain();
        check("t2_step_sum", bus.out_sum, 16'hFF00);
        check("t2_step_pred", bus.out_pred, 16'h0000);
        send(16'h0000, 16'h0000, 2'd1); drain();
        check("t2_relu_pred", bus.out_pred, 16'h0000);
        send(16'h0000, 16'h0000, 2'd2); drain();
        check("t2_lin_pred", bus.out_pred, 16'hFF00);

        // Saturation at both rails
        wr(0, 0, 16'h7FFF); wr(0, 1, 16'h7FFF); wr(1, 0, 16'h0000);
        send(16'h7FFF, 16'h7FFF, 2'd2); drain();
        check("t3_sat_pos", bus.out_sum, 16'h7FFF);
        send(16'h8001, 16'h8001, 2'd2); drain();
        check("t3_sat_neg", bus.out_sum, 16'h8000);

        // Random weights and back-to-back samples; spacing must be SIZE+3
        for (int r = 0; r < 3; r++) begin
            wr(0, 0, 16'($urandom)); wr(0, 1, 16'($urandom)); wr(1, 0, 16'($urandom_range(0, 16'h0FFF)));
            last = -1;
            for (int j = 0; j < 4; j++) begin
                send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
                if (last >= 0) check("throughput", cyc - last, SIZE + 3);
                last = cyc;
            end
            drain();
        end

        // Backpressure: outputs hold, no accepts, weight write blocked
        wr(0, 0, 16'h0100); wr(0, 1, 16'h0080); wr(1, 0, 16'h0000);
        bus.out_ready = 0;
        send(16'h0200, 16'h0100, 2'd2);
        wait_valid();
        sv = bus.out_sum; pv = bus.out_pred;
        bus.wt_valid = 1; bus.wt_is_bias = 0; bus.wt_idx = 1'b0; bus.wt_data = 16'h1234;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("bp_valid", bus.out_valid, 1);
            check("bp_sum", bus.out_sum, sv);
            check("bp_pred", bus.out_pred, pv);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_wt_ready", bus.wt_ready, 0);
        end
        bus.wt_valid = 0;
        bus.out_ready = 1;
        drain();
        send(16'h0100, 16'h0000, 2'd2); drain();
        check("bp_no_write", bus.out_sum, 16'h0100);

        // Weight write wins over a simultaneous sample
        bus.wt_valid = 1; bus.wt_is_bias = 0; bus.wt_idx = 1'b1; bus.wt_data = 16'h0200;
        bus.in_valid = 1; bus.in_data = {16'h0100, 16'h0100}; bus.activation = 2'd2;
        @(negedge clk);
        check("prio_in_ready", bus.in_ready, 0);
        check("prio_wt_ready", bus.wt_ready, 1);
        @(posedge clk); #1;
        bus.wt_valid = 0; w_m[1] = 16'h0200;
        @(negedge clk);
        check("prio_in_ready2", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 0;
        exp_q.push_back(model(16'h0100, 16'h0100, 2'd2));
        acc_q.push_back(cyc);
        drain();
        check("prio_new_wt", bus.out_sum, 16'h0300);

        // Reset while a result is pending
        bus.out_ready = 0;
        send(16'h0100, 16'h0100, 2'd2);
        wait_valid();
        #2 rst_n = 0; clear_model();
        #1;
        check("rst_out_drop", bus.out_valid, 0);
        check("rst_out_wt_ready", bus.wt_ready, 1);
        @(negedge clk); rst_n = 1; bus.out_ready = 1;
        @(posedge clk); #1;

        // Reset during MAC discards the sample and clears weights
        wr(0, 0, 16'h0100); wr(0, 1, 16'h0100); wr(1, 0, 16'h0100);
        send(16'h0100, 16'h0100, 2'd2);
        #2 rst_n = 0; clear_model();
        #1;
        check("rst_mac_valid", bus.out_valid, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        send(16'h0300, 16'h0200, 2'd2); drain();
        check("rst_wts_zero", bus.out_sum, 16'h0000);

        // Activation code 3
        wr(0, 0, 16'h0100); wr(0, 1, 16'h0000); wr(1, 0, 16'h0000);
        send(16'h0000, 16'h0000, 2'd3); drain();
`ifdef PERCEPTRON_HARDSIG_EN
        check("hs_zero", bus.out_pred, 16'h0080);
`else
        check("hs_zero", bus.out_pred, 16'h0000);
`endif
        send(16'h0400, 16'h0000, 2'd3); drain();
`ifdef PERCEPTRON_HARDSIG_EN
        check("hs_pos", bus.out_pred, 16'h0100);
`else
        check("hs_pos", bus.out_pred, 16'h0400);
`endif
        wr(1, 0, 16'hFC00);
        send(16'h0000, 16'h0000, 2'd3); drain();
`ifdef PERCEPTRON_HARDSIG_EN
        check("hs_neg", bus.out_pred, 16'h0000);
`else
        check("hs_neg", bus.out_pred, 16'hFC00);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
